// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the CPU memory path.
//   WORD_W      - data word width
//   mem_state_t - responder FSM states
//   mem_op_t    - latched request kind
package cpu_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } mem_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } mem_op_t;

  // Wait-state count loaded at acceptance; a read wins when both strobes are high.
  function automatic logic [3:0] lat_sel(input logic rd, input logic [3:0] rd_lat,
                                         input logic [3:0] wr_lat);
    logic [3:0] lat;
    if (rd) begin
      lat = rd_lat;
    end else begin
      lat = wr_lat;
    end
    return lat;
  endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x WORD_W single-port synchronous RAM, registered read, no reset.
//   clk   - clock, rising edge
//   we    - write enable
//   addr  - word index
//   wdata - write data
//   rdata - read data of addr sampled at the previous edge (old data on a write edge)
module mem_array
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Storage write and registered read port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: MAR/MDR memory responder with configurable wait states.
//   Clock   - clock, rising edge
//   Clear   - asynchronous active-low reset
//   Read    - read request strobe
//   Write   - write request strobe (loses to Read when both are high)
//   MARout  - word address, only [ADDR_W-1:0] used
//   MDRout  - write data
//   Mdatain - registered read data, held until the next read completes
//   Done    - one-cycle access-complete pulse
module mem_responder
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] MARout,
  input  logic [31:0] MDRout,
  output logic [31:0] Mdatain,
  output logic        Done
);

  localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);
  localparam logic [3:0] WR_LAT_C = 4'(WR_LAT);

  mem_state_t        state_q, state_d;
  mem_op_t           op_q, op_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] mdata_q, mdata_d;
  logic              done_q, done_d;

  logic              arr_we_s;
  logic [ADDR_W-1:0] arr_addr_s;
  logic [WORD_W-1:0] arr_rdata_s;
  logic              unused_s;

  // Upper address bits are deliberately dropped so addresses wrap.
  assign unused_s = ^MARout[31:ADDR_W];

  mem_array #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem_array (
    .clk  (Clock),
    .we   (arr_we_s),
    .addr (arr_addr_s),
    .wdata(wdata_q),
    .rdata(arr_rdata_s)
  );

  // Next-state, request latching and array control.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mdata_d    = mdata_q;
    done_d     = 1'b0;
    arr_we_s   = 1'b0;
    arr_addr_s = addr_q;
    case (state_q)
      IDLE: begin
        // The RAM sees the live address in IDLE so that a zero-latency read
        // already has its data registered at the acceptance edge.
        arr_addr_s = MARout[ADDR_W-1:0];
        if (Read || Write) begin
          state_d = BUSY;
          addr_d  = MARout[ADDR_W-1:0];
          wdata_d = MDRout;
          op_d    = Read ? OP_RD : OP_WR;
          cnt_d   = lat_sel(Read, RD_LAT_C, WR_LAT_C);
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          done_d  = 1'b1;
          state_d = DONE;
          if (op_q == OP_RD) begin
            mdata_d = arr_rdata_s;
          end else begin
            arr_we_s = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        // Wait for both strobes to drop: one Done per strobe assertion.
        if (Read || Write) begin
          state_d = RELEASE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any pending access.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      mdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mdata_q <= mdata_d;
      done_q  <= done_d;
    end
  end

  assign Mdatain = mdata_q;
  assign Done    = done_q;

endmodule
